// File: rtl/vram_share_ctrl.sv
// vram_share_ctrl: shared video RAM arbiter and strobe sequencer for two CPUs; define VRAM_SHARE_RR_EN for round-robin ties, else CPU A wins ties
module vram_share_ctrl #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_req,
    input  logic       a_rd_n,
    input  logic       a_wr_n,
    input  logic [7:0] a_dout,
    output logic [7:0] a_din,
    output logic       a_wait_n,
    input  logic       b_req,
    input  logic       b_rd_n,
    input  logic       b_wr_n,
    input  logic [7:0] b_dout,
    output logic [7:0] b_din,
    output logic       b_wait_n,
    output logic       ab_sel,
    input  logic [7:0] ram_din,
    output logic [7:0] ram_dout,
    output logic       ram_we_n,
    output logic       ram_oe_n,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t state;
    logic owner, op_wr, a_qreq, b_qreq, win, win_wr;
    logic [3:0] cnt;
`ifdef VRAM_SHARE_RR_EN
    logic last_owner;
`endif
    always_comb begin
        a_qreq = a_req & (~a_rd_n | ~a_wr_n);
        b_qreq = b_req & (~b_rd_n | ~b_wr_n);
`ifdef VRAM_SHARE_RR_EN
        win = (a_qreq & b_qreq) ? ~last_owner : ~a_qreq;
`else
        win = ~a_qreq;
`endif
        win_wr = win ? (~b_wr_n & b_rd_n) : (~a_wr_n & a_rd_n);
        busy = state != IDLE;
        a_wait_n = reset | ~a_req | (state == DONE & ~owner);
        b_wait_n = reset | ~b_req | (state == DONE & owner);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ab_sel   <= 1'b0;
            owner    <= 1'b0;
            op_wr    <= 1'b0;
            cnt      <= '0;
            ram_we_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_dout <= '0;
            a_din    <= '0;
            b_din    <= '0;
`ifdef VRAM_SHARE_RR_EN
            last_owner <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: if (a_qreq | b_qreq) begin
                    ab_sel   <= win;
                    owner    <= win;
                    op_wr    <= win_wr;
                    ram_dout <= win ? b_dout : a_dout;
                    cnt      <= 4'(ACCESS_CYCLES - 1);
                    ram_we_n <= ~win_wr;
                    ram_oe_n <= win_wr;
                    state    <= ACC;
                end
                ACC: if (cnt == '0) begin
                    if (!op_wr) begin
                        if (owner) b_din <= ram_din;
                        else a_din <= ram_din;
                    end
                    ram_we_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    state    <= DONE;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE: if (!(owner ? b_req : a_req)) begin
`ifdef VRAM_SHARE_RR_EN
                    last_owner <= owner;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_share_ctrl.sv
// tb_vram_share_ctrl: scoreboard bench for vram_share_ctrl; completed accesses are matched against a queue of expected transfers
module tb_vram_share_ctrl;
    localparam int AC = 2;
    typedef struct {
        logic       sel;
        logic       wr;
        logic [7:0] data;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1;
    logic a_req = 1'b0, a_rd_n = 1'b1, a_wr_n = 1'b1, b_req = 1'b0, b_rd_n = 1'b1, b_wr_n = 1'b1;
    logic [7:0] a_dout = '0, b_dout = '0, ram_din = '0;
    logic [7:0] a_din, b_din, ram_dout;
    logic a_wait_n, b_wait_n, ab_sel, ram_we_n, ram_oe_n, busy;
    exp_t q[$];
    exp_t e;
    int pass_cnt = 0, chk_cnt = 0, len = 0;
    logic act = 1'b0, saw_we = 1'b0;
    logic [7:0] wdat = '0;

    always #5 clk = ~clk;

    vram_share_ctrl #(.ACCESS_CYCLES(AC)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_rd_n(a_rd_n), .a_wr_n(a_wr_n), .a_dout(a_dout), .a_din(a_din), .a_wait_n(a_wait_n),
        .b_req(b_req), .b_rd_n(b_rd_n), .b_wr_n(b_wr_n), .b_dout(b_dout), .b_din(b_din), .b_wait_n(b_wait_n),
        .ab_sel(ab_sel), .ram_din(ram_din), .ram_dout(ram_dout), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input string tag, input int sel, input int exp_n);
        int n = 0;
        logic hit = 1'b0;
        while (!hit && n < 20) begin
            step();
            n++;
            hit = sel == 0 ? a_wait_n : sel == 1 ? b_wait_n : ab_sel;
        end
        chk(tag, n, exp_n);
    endtask

    task automatic tie(input logic [7:0] d, input logic w);
        ram_din = d;
        a_req = 1'b1; a_rd_n = 1'b0;
        b_req = 1'b1; b_rd_n = 1'b0;
        q.push_back(exp_t'{w, 1'b0, d});
        wait_for("tie_rel", w ? 1 : 0, AC + 1);
        chk("tie_loser_wait", w ? a_wait_n : b_wait_n, 0);
        a_req = 1'b0; a_rd_n = 1'b1;
        b_req = 1'b0; b_rd_n = 1'b1;
        repeat (3) step();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            len = 0;
            act = 1'b0;
            saw_we = 1'b0;
        end else if (!ram_we_n || !ram_oe_n) begin
            len++;
            act = 1'b1;
            if (!ram_we_n) begin
                saw_we = 1'b1;
                wdat = ram_dout;
            end
        end else if (act) begin
            if (q.size() == 0) chk("sb_unexpected", 1, 0);
            else begin
                e = q.pop_front();
                chk("sb_len", len, AC);
                chk("sb_sel", ab_sel, e.sel);
                chk("sb_op", saw_we, e.wr);
                chk("sb_data", e.wr ? wdat : (e.sel ? b_din : a_din), e.data);
            end
            len = 0;
            act = 1'b0;
            saw_we = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a_req = 1'b1;
        repeat (3) step();
        chk("rst_sel", ab_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", ram_we_n, 1);
        chk("rst_oe", ram_oe_n, 1);
        chk("rst_dout", ram_dout, 0);
        chk("rst_adin", a_din, 0);
        chk("rst_bdin", b_din, 0);
        chk("rst_await", a_wait_n, 1);
        chk("rst_bwait", b_wait_n, 1);
        reset = 1'b0; a_req = 1'b0;
        repeat (2) step();

        ram_din = 8'h5A; a_req = 1'b1; a_rd_n = 1'b0;
        q.push_back(exp_t'{1'b0, 1'b0, 8'h5A});
        step();
        chk("ar_oe", ram_oe_n, 0);
        chk("ar_sel", ab_sel, 0);
        chk("ar_busy", busy, 1);
        chk("ar_wait", a_wait_n, 0);
        wait_for("ar_rel", 0, AC);
        chk("ar_din", a_din, 8'h5A);
        chk("ar_bdin", b_din, 0);
        a_req = 1'b0; a_rd_n = 1'b1;
        repeat (3) step();

        b_req = 1'b1; b_dout = 8'hC3;
        step();
        chk("bw_nogrant_busy", busy, 0);
        chk("bw_nogrant_we", ram_we_n, 1);
        chk("bw_held", b_wait_n, 0);
        b_wr_n = 1'b0;
        q.push_back(exp_t'{1'b1, 1'b1, 8'hC3});
        wait_for("bw_rel", 1, AC + 1);
        chk("bw_dout", ram_dout, 8'hC3);
        b_req = 1'b0; b_wr_n = 1'b1;
        repeat (3) step();

        ram_din = 8'h11;
        a_req = 1'b1; a_rd_n = 1'b0;
        b_req = 1'b1; b_rd_n = 1'b0;
        q.push_back(exp_t'{1'b0, 1'b0, 8'h11});
        wait_for("ab_a_rel", 0, AC + 1);
        chk("ab_b_held", b_wait_n, 0);
        ram_din = 8'h22;
        q.push_back(exp_t'{1'b1, 1'b0, 8'h22});
        a_req = 1'b0; a_rd_n = 1'b1;
        wait_for("ab_b_grant", 2, 2);
        wait_for("ab_b_rel", 1, AC);
        chk("ab_adin", a_din, 8'h11);
        b_req = 1'b0; b_rd_n = 1'b1;
        repeat (3) step();

        tie(8'h33, 1'b0);
`ifdef VRAM_SHARE_RR_EN
        tie(8'h44, 1'b1);
`else
        tie(8'h44, 1'b0);
`endif
        tie(8'h55, 1'b0);

        a_req = 1'b1; a_wr_n = 1'b0; a_dout = 8'h7E;
        q.push_back(exp_t'{1'b0, 1'b1, 8'h7E});
        step();
        chk("dr_we", ram_we_n, 0);
        a_req = 1'b0; a_wr_n = 1'b1;
        step();
        step();
        chk("dr_busy_done", busy, 1);
        step();
        chk("dr_idle", busy, 0);
        repeat (2) step();

        b_req = 1'b1; b_wr_n = 1'b0; b_dout = 8'h99;
        step();
        chk("rs_we_pre", ram_we_n, 0);
        reset = 1'b1;
        step();
        chk("rs_we", ram_we_n, 1);
        chk("rs_busy", busy, 0);
        chk("rs_sel", ab_sel, 0);
        chk("rs_await", a_wait_n, 1);
        chk("rs_bwait", b_wait_n, 1);
        chk("rs_adin", a_din, 0);
        chk("rs_bdin", b_din, 0);
        chk("rs_dout", ram_dout, 0);
        b_req = 1'b0; b_wr_n = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();

        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
